// File: rtl/lap_timer_core.sv
// lap_timer_core
//   Stopwatch / countdown core with a lap-capture FIFO.
//   Counts hundredths, seconds, minutes and hours from a divided system clock.
//   It counts up from zero, or down from a saturated preset to zero.
//   Split times are pushed into a show-ahead FIFO that the display side drains.
//
// Parameters
//   TICK_DIV  : clock cycles per hundredth-second tick (>= 2)
//   LAP_DEPTH : lap FIFO entries (power of two, >= 2)
//   HOUR_MAX  : largest hour value (<= 127)
//
// Ports
//   clock_i          system clock
//   reset_i          synchronous active-high reset
//   start_pause_i    one-cycle pulse: start / pause / resume
//   lap_i            one-cycle pulse: capture the current timestamp
//   clear_i          one-cycle pulse: back to idle, reload time, empty FIFO
//   count_down_i     mode select, sampled on clear_i only
//   preset_i         countdown start value, packed like timestamp_o
//   timestamp_o      {hour[27:21], minute[20:14], second[13:7], m_sec[6:0]}
//   running_o        high while counting
//   expired_o        one-cycle pulse when a countdown reaches zero
//   lap_rd_i         pop request for the lap FIFO
//   lap_data_o       FIFO head, zero when empty
//   lap_valid_o      FIFO non-empty
//   lap_count_o      entries held
//   lap_overflow_o   sticky: a lap was dropped because the FIFO was full
module lap_timer_core #(
    parameter int unsigned TICK_DIV  = 500000,
    parameter int unsigned LAP_DEPTH = 8,
    parameter int unsigned HOUR_MAX  = 99
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               start_pause_i,
    input  logic                               lap_i,
    input  logic                               clear_i,
    input  logic                               count_down_i,
    input  logic [27:0]                        preset_i,
    output logic [27:0]                        timestamp_o,
    output logic                               running_o,
    output logic                               expired_o,
    input  logic                               lap_rd_i,
    output logic [27:0]                        lap_data_o,
    output logic                               lap_valid_o,
    output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count_o,
    output logic                               lap_overflow_o
);

    localparam int unsigned DivW = $clog2(TICK_DIV);
    localparam int unsigned PtrW = $clog2(LAP_DEPTH);
    localparam int unsigned CntW = $clog2(LAP_DEPTH + 1);

    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(LAP_DEPTH);
    localparam logic [6:0]      MsMax   = 7'd99;
    localparam logic [6:0]      SecMax  = 7'd59;
    localparam logic [6:0]      MinMax  = 7'd59;
    localparam logic [6:0]      HourMax = 7'(HOUR_MAX);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    // State registers
    state_e            state_q, state_d;
    logic              mode_q, mode_d;           // 1: count down
    logic [6:0]        hour_q, hour_d;
    logic [6:0]        min_q, min_d;
    logic [6:0]        sec_q, sec_d;
    logic [6:0]        ms_q, ms_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              running_q, running_d;
    logic              expired_q, expired_d;

    // Lap FIFO
    logic [27:0]       mem_q [LAP_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [27:0]       head_q, head_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;

    logic              tick;
    logic              push_req;
    logic              push_ok;
    logic              pop_ok;
    logic [27:0]       ts_q;
    logic              ts_zero;

    // Saturated preset fields
    logic [6:0]        pre_hour, pre_min, pre_sec, pre_ms;

    // Timestamp after one tick in the current mode
    logic [6:0]        tk_hour, tk_min, tk_sec, tk_ms;

    assign ts_q    = {hour_q, min_q, sec_q, ms_q};
    assign ts_zero = (ts_q == '0);

    always_comb begin
        pre_hour = (preset_i[27:21] > HourMax) ? HourMax : preset_i[27:21];
        pre_min  = (preset_i[20:14] > MinMax)  ? MinMax  : preset_i[20:14];
        pre_sec  = (preset_i[13:7]  > SecMax)  ? SecMax  : preset_i[13:7];
        pre_ms   = (preset_i[6:0]   > MsMax)   ? MsMax   : preset_i[6:0];
    end

    // Carry / borrow ripples through all fields in one cycle.
    always_comb begin
        tk_hour = hour_q;
        tk_min  = min_q;
        tk_sec  = sec_q;
        tk_ms   = ms_q;
        if (!mode_q) begin
            if (ms_q == MsMax) begin
                tk_ms = '0;
                if (sec_q == SecMax) begin
                    tk_sec = '0;
                    if (min_q == MinMax) begin
                        tk_min  = '0;
                        tk_hour = (hour_q == HourMax) ? 7'd0 : hour_q + 7'd1;
                    end else begin
                        tk_min = min_q + 7'd1;
                    end
                end else begin
                    tk_sec = sec_q + 7'd1;
                end
            end else begin
                tk_ms = ms_q + 7'd1;
            end
        end else begin
            if (ms_q == '0) begin
                tk_ms = MsMax;
                if (sec_q == '0) begin
                    tk_sec = SecMax;
                    if (min_q == '0) begin
                        tk_min  = MinMax;
                        tk_hour = hour_q - 7'd1;
                    end else begin
                        tk_min = min_q - 7'd1;
                    end
                end else begin
                    tk_sec = sec_q - 7'd1;
                end
            end else begin
                tk_ms = ms_q - 7'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        ms_d       = ms_q;
        div_d      = div_q;
        expired_d  = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tick       = 1'b0;
        push_req   = 1'b0;
        push_ok    = 1'b0;
        pop_ok     = 1'b0;

        if (clear_i) begin
            state_d    = StIdle;
            mode_d     = count_down_i;
            if (count_down_i) begin
                hour_d = pre_hour;
                min_d  = pre_min;
                sec_d  = pre_sec;
                ms_d   = pre_ms;
            end else begin
                hour_d = '0;
                min_d  = '0;
                sec_d  = '0;
                ms_d   = '0;
            end
            div_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // Divider only advances in RUN; PAUSE keeps the fractional tick.
            if (state_q == StRun) begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    tick  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle:  if (start_pause_i && !(mode_q && ts_zero)) state_d = StRun;
                StRun:   if (start_pause_i) state_d = StPause;
                StPause: if (start_pause_i) state_d = StRun;
                StDone:  ;
                default: state_d = StIdle;
            endcase

            if (tick) begin
                hour_d = tk_hour;
                min_d  = tk_min;
                sec_d  = tk_sec;
                ms_d   = tk_ms;
                // Reaching zero wins over a same-cycle pause.
                if (mode_q && ({tk_hour, tk_min, tk_sec, tk_ms} == '0)) begin
                    state_d   = StDone;
                    expired_d = 1'b1;
                end
            end

            // Lap captures the pre-tick timestamp.
            push_req = lap_i && ((state_q == StRun) || (state_q == StPause));
            pop_ok   = lap_rd_i && (count_q != '0);
            push_ok  = push_req && ((count_q != CntFull) || pop_ok);
            if (push_req && !push_ok) begin
                overflow_d = 1'b1;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end

        running_d = (state_d == StRun);
        valid_d   = (count_d != '0);

        // Registered show-ahead head; a push into the slot about to become
        // the head bypasses the memory.
        if (count_d == '0) begin
            head_d = '0;
        end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = ts_q;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            ms_q       <= '0;
            div_q      <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            ms_q       <= ms_d;
            div_q      <= div_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= ts_q;
            end
        end
    end

    assign timestamp_o    = ts_q;
    assign running_o      = running_q;
    assign expired_o      = expired_q;
    assign lap_data_o     = head_q;
    assign lap_valid_o    = valid_q;
    assign lap_count_o    = count_q;
    assign lap_overflow_o = overflow_q;

endmodule

// File: doc/lap_timer_core.md
# lap_timer_core

Parametrised stopwatch/countdown core that succeeds the fixed single-mode timer behind the stopwatch top level. It counts hundredths, seconds, minutes and hours from a divided system clock and runs either up from zero or down from a preset. It also captures split times into an internal lap FIFO that the LCD/display side drains. It sits between the key-logic FSM (single-cycle command pulses) and the bin2bcd/bcd2seg display path.

## Interface
- TICK_DIV, 500000: clock cycles per hundredth-second tick (50 MHz → 100 Hz); ≥ 2
- LAP_DEPTH, 8: lap FIFO entries; power of two, ≥ 2
- HOUR_MAX, 99: largest hour value; ≤ 127
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; all state to reset values
- start_pause  in  1  one-cycle command pulse: start/resume/pause
- lap  in  1  one-cycle pulse: capture current timestamp into lap FIFO
- clear  in  1  one-cycle pulse: return to IDLE, empty FIFO, reload time
- count_down  in  1  mode select, sampled only on clear
- preset  in  28  countdown start value, same packing as timestamp
- timestamp  out  28  {hour[27:21], minute[20:14], second[13:7], m_sec[6:0]}, binary
- running  out  1  high in RUN
- expired  out  1  one-cycle pulse when countdown reaches zero
- lap_rd  in  1  pop request for lap FIFO
- lap_data  out  28  FIFO head (show-ahead); 0 when empty
- lap_valid  out  1  FIFO non-empty
- lap_count  out  $clog2(LAP_DEPTH+1)  entries held
- lap_overflow  out  1  sticky: a lap was dropped while FIFO full

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE, mode = count-up, timestamp = 0, divider = 0, FIFO empty, lap_overflow = 0, expired = 0, running = 0.
- Priority: reset > clear > start_pause/lap (start_pause and lap act together).
- clear (any state): → IDLE. Latch mode from count_down. Load timestamp = 0 (up) or preset (down). Saturate each out-of-range preset field to its max (99/59/59/HOUR_MAX). Divider = 0. Empty FIFO, lap_overflow = 0.
- start_pause: IDLE → RUN (ignored in down mode when timestamp = 0). RUN → PAUSE. PAUSE → RUN. DONE: ignored.
- Divider counts only in RUN. A tick fires when it equals TICK_DIV-1, then it wraps to 0. PAUSE holds the divider value, so fractional ticks are preserved.
- Up count on tick: m_sec 0..99, second 0..59, minute 0..59, hour 0..HOUR_MAX. Carry ripples in the same cycle. All-max wraps to all-zero and RUN continues.
- Down count on tick: decrement with borrow (m_sec 0 → 99, second/minute 0 → 59). Reaching exactly 0 → DONE, expired = 1 for that one cycle, running = 0. The timestamp holds 0.
- lap in RUN or PAUSE pushes the timestamp value registered before any same-cycle tick update. lap in IDLE/DONE is ignored.
- Push when full: entry dropped, lap_overflow set until clear/reset. Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
- lap_rd when empty: ignored. Push and pop in the same cycle when empty: push only.

## Timing
- All outputs registered. Command at edge n → state/running change visible after edge n.
- Start: first tick is TICK_DIV cycles after the start_pause cycle. timestamp updates on the edge after the tick condition.
- expired asserts in the same cycle timestamp becomes 0 and running drops.
- Push: lap_valid/lap_count/lap_data update the cycle after lap. Pop: the next head appears the cycle after lap_rd.
- reset mid-run or mid-push: the next cycle shows only reset values. No partial push is retained.

## Test plan
- TICK_DIV=4, up mode: clear, start, run 400 cycles → timestamp m_sec=100 ticks ⇒ {0,0,1,0}. running=1 throughout.
- Pause after 10 cycles (divider=2), wait 50, resume → next tick after exactly 2 cycles. Timestamp frozen during pause.
- Down mode, preset {0,0,1,2}: start, 102 ticks → timestamp 0, expired one-cycle pulse, state DONE. start_pause ignored until clear.
- LAP_DEPTH=4: 5 laps at distinct times → lap_count=4, lap_overflow=1. Four pops return the first 4 timestamps in order, then lap_valid=0.
- lap on the same cycle as a tick carry {0,0,0,99}→{0,0,1,0} → captured value {0,0,0,99}. Full FIFO with lap+lap_rd → count stays 4, overflow stays 0.
- Wrap: up mode, HOUR_MAX=1, preset-free run forced near {1,59,59,99} via a long sim → next tick gives all-zero, running stays 1. Preset {0,75,0,0} in down mode clamps to minute=59.
